// File: rtl/butterfly_pipe.sv
// Pipelined modular butterfly for the NTT/INTT datapath: CT, GS (with halving),
// add/sub and multiply modes share one multiplier and one fixed latency.
module butterfly_pipe #(
  parameter int WIDTH   = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_w,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_e,
  output logic [WIDTH-1:0] out_o,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_mode,
  output logic             busy
);

  typedef enum logic [1:0] {
    MODE_CT     = 2'd0,
    MODE_GS     = 2'd1,
    MODE_ADDSUB = 2'd2,
    MODE_MUL    = 2'd3
  } mode_e;

  typedef struct packed {
    logic             valid;
    mode_e            mode;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] w;
  } raw_t;

  typedef struct packed {
    logic             valid;
    mode_e            mode;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
  } meta_t;

  localparam logic [WIDTH-1:0]   QW = WIDTH'(Q);
  localparam logic [WIDTH:0]     QX = (WIDTH+1)'(Q);
  localparam logic [2*WIDTH-1:0] QP = (2*WIDTH)'(Q);

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= QX) ? WIDTH'(s - QX) : WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (x >= y) ? (x - y) : (x + (QW - y));
  endfunction

  // Division by two in the field: odd values borrow a Q to become even.
  function automatic logic [WIDTH-1:0] mod_half(input logic [WIDTH-1:0] x);
    return x[0] ? WIDTH'(({1'b0, x} + QX) >> 1) : (x >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] mod_red(input logic [2*WIDTH-1:0] p);
    return WIDTH'(p % QP);
  endfunction

  logic             adv;
  raw_t             raw_d;
  raw_t             raw_q;
  meta_t            pre_d;
  logic [WIDTH-1:0] opnd_d;
  meta_t            meta_q [MUL_LAT+1];
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] w_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0] mr;
  meta_t            fin;
  logic [WIDTH-1:0] res_e;
  logic [WIDTH-1:0] res_o;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  always_comb begin
    raw_d       = '0;
    raw_d.valid = in_valid;
    raw_d.mode  = mode_e'(in_mode);
    raw_d.tag   = in_tag;
    raw_d.a     = in_a;
    raw_d.b     = in_b;
    raw_d.w     = in_w;
  end

  // Pre-stage: form a+b, a-b and pick the single multiplier operand per mode.
  always_comb begin
    pre_d       = '0;
    pre_d.valid = raw_q.valid;
    pre_d.mode  = raw_q.mode;
    pre_d.tag   = raw_q.tag;
    pre_d.a     = raw_q.a;
    pre_d.sum   = mod_add(raw_q.a, raw_q.b);
    pre_d.diff  = mod_sub(raw_q.a, raw_q.b);
    opnd_d      = '0;
    case (raw_q.mode)
      MODE_CT:  opnd_d = raw_q.b;
      MODE_GS:  opnd_d = pre_d.diff;
      MODE_MUL: opnd_d = raw_q.a;
      default:  opnd_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q  <= '0;
      opnd_q <= '0;
      w_q    <= '0;
      prod_q <= '0;
      for (int i = 0; i <= MUL_LAT; i++) meta_q[i] <= '0;
    end else if (adv) begin
      raw_q     <= raw_d;
      meta_q[0] <= pre_d;
      opnd_q    <= opnd_d;
      w_q       <= raw_q.w;
      prod_q    <= {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, w_q};
      for (int i = 1; i <= MUL_LAT; i++) meta_q[i] <= meta_q[i-1];
    end
  end

  // Reduction is registered right after the product when depth allows it.
  if (MUL_LAT == 1) begin : g_red_comb
    assign mr = mod_red(prod_q);
  end else begin : g_red_pipe
    logic [WIDTH-1:0] red_q [MUL_LAT-1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < MUL_LAT-1; i++) red_q[i] <= '0;
      end else if (adv) begin
        red_q[0] <= mod_red(prod_q);
        for (int i = 1; i < MUL_LAT-1; i++) red_q[i] <= red_q[i-1];
      end
    end
    assign mr = red_q[MUL_LAT-2];
  end

  always_comb begin
    fin   = meta_q[MUL_LAT];
    res_e = '0;
    res_o = '0;
    case (fin.mode)
      MODE_CT: begin
        res_e = mod_add(fin.a, mr);
        res_o = mod_sub(fin.a, mr);
      end
      MODE_GS: begin
        res_e = mod_half(fin.sum);
        res_o = mod_half(mr);
      end
      MODE_ADDSUB: begin
        res_e = fin.sum;
        res_o = fin.diff;
      end
      default: begin
        res_e = mr;
        res_o = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_e     <= '0;
      out_o     <= '0;
      out_tag   <= '0;
      out_mode  <= '0;
    end else if (adv) begin
      out_valid <= fin.valid;
      out_e     <= res_e;
      out_o     <= res_o;
      out_tag   <= fin.tag;
      out_mode  <= fin.mode;
    end
  end

  always_comb begin
    busy = out_valid | raw_q.valid;
    for (int i = 0; i <= MUL_LAT; i++) busy = busy | meta_q[i].valid;
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed vectors, backpressure and
// random mixed-mode traffic against an arithmetic scoreboard.
module tb_butterfly_pipe;

  localparam int WIDTH   = 12;
  localparam int Q       = 3329;
  localparam int MUL_LAT = 3;
  localparam int TAG_W   = 8;
  localparam int LAT     = MUL_LAT + 2;
  localparam int OW      = 1 + 2*WIDTH + TAG_W + 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_w;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_e;
  logic [WIDTH-1:0] out_o;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_mode;
  logic             busy;

  butterfly_pipe #(.WIDTH(WIDTH), .Q(Q), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_e(out_e), .out_o(out_o), .out_tag(out_tag), .out_mode(out_mode),
    .busy(busy)
  );

  typedef struct {
    int e;
    int o;
    int tag;
    int mode;
    int acc;
    int stl;
  } exp_t;

  exp_t          sb[$];
  exp_t          px;
  exp_t          nx;
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            stalls = 0;
  int            popped = 0;
  int            rdy_mode = 0;
  int            ph = 0;
  bit            prev_stall = 0;
  logic [OW-1:0] held;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every comparison goes through here.
  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int half(input int x);
    return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
  endfunction

  // Reference arithmetic straight from the mode definitions.
  task automatic model(input int m, input int a, input int b, input int w, output int e, output int o);
    int t;
    case (m)
      0: begin
        t = (w * b) % Q;
        e = (a + t) % Q;
        o = (a - t + Q) % Q;
      end
      1: begin
        e = half((a + b) % Q);
        o = half((((a - b + Q) % Q) * w) % Q);
      end
      2: begin
        e = (a + b) % Q;
        o = (a - b + Q) % Q;
      end
      default: begin
        e = (a * w) % Q;
        o = 0;
      end
    endcase
  endtask

  function automatic int rndc();
    return int'($urandom_range(0, Q-1));
  endfunction

  // Scoreboard: values sampled mid-cycle describe the transfers at the next edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      checkOutput("in_ready", in_ready, out_ready | !out_valid);
      checkOutput("busy", busy, sb.size() != 0);
      if (prev_stall)
        checkOutput("stall_hold", {out_valid, out_e, out_o, out_tag, out_mode}, held);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_out", 1, 0);
        end else begin
          px = sb.pop_front();
          checkOutput("out_tag", out_tag, px.tag);
          checkOutput("out_mode", out_mode, px.mode);
          checkOutput("out_e", out_e, px.e);
          checkOutput("out_o", out_o, px.o);
          checkOutput("latency", (cyc + 1) - px.acc - (stalls - px.stl), LAT + 1);
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        model(in_mode, in_a, in_b, in_w, nx.e, nx.o);
        nx.tag  = in_tag;
        nx.mode = in_mode;
        nx.acc  = cyc + 1;
        nx.stl  = stalls;
        sb.push_back(nx);
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) begin
        held = {out_valid, out_e, out_o, out_tag, out_mode};
        stalls++;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic applyStimulus(input int m, input int a, input int b, input int w, input int t);
    int n;
    bit done;
    n = 0;
    done = 0;
    in_valid = 1'b1;
    in_mode  = m[1:0];
    in_a     = a[WIDTH-1:0];
    in_b     = b[WIDTH-1:0];
    in_w     = w[WIDTH-1:0];
    in_tag   = t[TAG_W-1:0];
    while (!done && n < 200) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic setIdle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int de[4]  = '{3328, 1669, 1, 1};
  int dox[4] = '{1, 1663, 3326, 0};
  int p0;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_mode = '0;
    in_a = '0;
    in_b = '0;
    in_w = '0;
    in_tag = '0;
    #1;
    checkOutput("reset_outs", {out_valid, out_e, out_o, out_tag, out_mode}, 0);
    checkOutput("reset_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 checkOutput("ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // Operations in flight are dropped by an asynchronous reset.
    for (int i = 0; i < 3; i++)
      applyStimulus(int'($urandom_range(0, 3)), rndc(), rndc(), rndc(), 40 + i);
    setIdle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_reset_outs", {out_valid, out_e, out_o, out_tag, out_mode}, 0);
    checkOutput("mid_reset_busy", busy, 0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1 checkOutput("ready_mid_reset", in_ready, 1);
    @(posedge clk);
    #1;

    applyStimulus(0, 5, 3, 2, 8'h11);
    setIdle();
    repeat (LAT-1) @(posedge clk);
    #1 checkOutput("ct_early", out_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("ct_valid", out_valid, 1);
    checkOutput("ct_e", out_e, 11);
    checkOutput("ct_o", out_o, 3328);
    checkOutput("ct_tag", out_tag, 8'h11);
    repeat (3) @(posedge clk);
    #1;

    applyStimulus(0, 0, 1, 3328, 0);
    applyStimulus(1, 3, 6, 1, 1);
    applyStimulus(2, 3328, 2, rndc(), 2);
    applyStimulus(3, 3328, rndc(), 3328, 3);
    setIdle();
    repeat (LAT-3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("mix_valid", out_valid, 1);
      checkOutput("mix_tag", out_tag, i);
      checkOutput("mix_mode", out_mode, i);
      checkOutput("mix_e", out_e, de[i]);
      checkOutput("mix_o", out_o, dox[i]);
      @(posedge clk);
      #1;
    end
    checkOutput("mix_done", out_valid, 0);

    rdy_mode = 1;
    p0 = popped;
    for (int i = 0; i < 10; i++) applyStimulus(0, rndc(), rndc(), rndc(), i);
    setIdle();
    drain();
    checkOutput("bp_count", popped - p0, 10);
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(int'($urandom_range(0, 3)), rndc(), rndc(), rndc(), i);
      if ($urandom_range(0, 3) == 0) begin
        setIdle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    setIdle();
    drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_busy", busy, 0);
    checkOutput("final_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/butterfly_pipe.md
# butterfly_pipe

Parametrised, fully pipelined modular butterfly unit for the NTT/INTT polynomial multiplier datapath. It executes a per-operation mode: CT butterfly, GS butterfly with halving, modular add/sub, or modular multiply. The mode travels down the pipeline alongside the data, so modes can change every cycle. A valid/ready handshake with whole-pipeline stall lets the unit sit between the coefficient-memory read port and a write-back stage that may backpressure.

## Interface
Parameters:
- WIDTH, 12: coefficient width in bits.
- Q, 3329: modulus. Must be odd, Q < 2^WIDTH.
- MUL_LAT, 3: internal modular-multiplier pipeline depth in cycles, ≥1.
- TAG_W, 8: width of the opaque sideband tag (address or index) carried with each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts this cycle.
- in_mode  in  2  0=CT, 1=GS, 2=ADDSUB, 3=MUL.
- in_a, in_b, in_w  in  WIDTH  operands and twiddle; each must be < Q (behaviour for values ≥ Q is unspecified).
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_e, out_o  out  WIDTH  results, always in [0, Q).
- out_tag  out  TAG_W  tag of the result.
- out_mode  out  2  mode of the result.
- busy  out  1  any valid operation inside the pipeline, including the output stage.

## Operation
Arithmetic (all mod Q; modular subtract x−y = x−y+Q if x<y):
- `half(x)` = x/2 if x even, else (x+Q)/2.
- CT: t=w·b; e=a+t; o=a−t.
- GS: e=half(a+b); o=half((a−b)·w).
- ADDSUB: e=a+b; o=a−b. w is ignored.
- MUL: e=a·w; o=0. b is ignored.

Datapath rules:
- Modular multiply is the full product (2·WIDTH bits) reduced to [0,Q).
- Internal sums are WIDTH+1 bits before conditional subtraction of Q.
- One shared multiplier. Its input operand is b (CT), a−b (GS) or a (MUL).
- Every mode has the same latency LAT = MUL_LAT + 2, so results leave strictly in acceptance order.
- Unused mux paths do not corrupt results.

Pipeline:
- LAT stages. Each stage holds a valid bit, mode, tag and data.
- Global advance enable: `adv = out_ready | ~out_valid`.
- in_ready = adv (combinational from out_ready and out_valid only).
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- When adv=0, all stages hold, including bubbles.
- When adv=1 and in_valid=0, a bubble enters.

## Timing
- Reset (asynchronous):
  - All valid bits, data, tag and mode registers are 0.
  - out_valid=0, out_e=0, out_o=0, out_tag=0, out_mode=0, busy=0.
  - in_ready=1 as soon as rst deasserts.
- Accept at edge k, no stalls: out_valid=1 with the result after edge k+LAT.
- Throughput: one operation per cycle while out_ready=1.
- Simultaneous transfer in and out in one cycle is legal and is the steady state.
- Stall: while out_valid=1 and out_ready=0:
  - out_* hold stable;
  - in_ready=0;
  - no stage changes.
- Bubbles are not compressed. Up to LAT operations are in flight.
- Reset mid-operation: all in-flight operations are discarded with no output; reset values apply immediately.
- Mode changing every cycle (CT, GS, ADDSUB, MUL, ...) produces each result per its own mode.

## Test plan
- Reset / single CT, Q=3329, MUL_LAT=3:
  - Assert rst mid-stream → outputs 0 and busy=0 asynchronously.
  - Then CT a=5, b=3, w=2 → after 5 cycles e=11, o=3328.
- CT wrap: a=0, b=1, w=3328 → e=3328, o=1.
- GS halving: a=3, b=6, w=1 → e=1669, o=1663.
- ADDSUB / MUL:
  - ADDSUB a=3328, b=2 → e=1, o=3326.
  - MUL a=3328, w=3328 → e=1, o=0.
- Back-to-back mixed modes:
  - Issue the four ops above on consecutive cycles with tags 0..3, out_ready=1.
  - Required: results on 4 consecutive cycles, in tag order, with matching out_mode.
- Backpressure:
  - Stream 10 CT ops, out_ready toggling 1,0,0,1,...
  - Required: in_ready mirrors adv; no result lost or duplicated; out_* stable during stalls.
  - Tags emerge 0..9 in order; busy falls only after the last transfer out.
